// File: rtl/axis_pool_pkg.sv
// Shared helpers for the ReLU/max-pool stage: index widths, signed max and u8 saturation.
// Pure functions only; no state, no latency.
package axis_pool_pkg;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic logic signed [63:0] smax(input logic signed [63:0] a,
                                               input logic signed [63:0] b);
      return (a > b) ? a : b;
   endfunction

   function automatic logic [7:0] sat_u8(input logic signed [63:0] v);
      if (v < 0)
         return 8'd0;
      else if (v > 64'sd255)
         return 8'hFF;
      else
         return v[7:0];
   endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of horizontal pair maxima from the even row of each pooling window.
// Write lands on the clock edge; read is combinational; no flow control.
module pool_line_buf #(
   parameter int DEPTH  = 12,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_dat,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_dat
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_addr] <= wr_dat;
   end

   assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/axis_relu_maxpool.sv
// ReLU + 2x2/stride-2 max pool on a raster AXI-Stream map; AXIS_POOL_REQUANT_EN adds u8 requant.
// Output registers on the edge accepting a window's last pixel; input stalls only while a beat waits.
module axis_relu_maxpool
   import axis_pool_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int MAP_W     = 24,
   parameter int MAP_H     = 24,
   parameter int OUT_SHIFT = 8
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic [DATA_W-1:0] S_AXIS_DataIn_tdata,
   input  logic              S_AXIS_DataIn_tvalid,
   output logic              S_AXIS_DataIn_tready,
   input  logic              S_AXIS_DataIn_tlast,
   output logic [DATA_W-1:0] M_AXIS_DataOut_tdata,
   output logic              M_AXIS_DataOut_tvalid,
   input  logic              M_AXIS_DataOut_tready,
   output logic              M_AXIS_DataOut_tlast,
   output logic              frame_done,
   output logic              err_tlast
);

   localparam int COL_W = idx_w(MAP_W);
   localparam int ROW_W = idx_w(MAP_H);
   localparam int LB_AW = idx_w(MAP_W / 2);

`ifdef AXIS_POOL_REQUANT_EN
   localparam bit REQUANT_EN = 1'b1;
`else
   localparam bit REQUANT_EN = 1'b0;
`endif
   localparam int EFF_SHIFT = REQUANT_EN ? OUT_SHIFT : 0;

   logic [COL_W-1:0]         col;
   logic [ROW_W-1:0]         row;
   logic signed [DATA_W-1:0] hold;
   logic signed [DATA_W-1:0] in_dat;
   logic signed [DATA_W-1:0] lb_rd;
   logic [LB_AW-1:0]         lb_addr;
   logic signed [63:0]       pair_w;
   logic signed [63:0]       pool_w;
   logic signed [63:0]       shf_w;
   logic [DATA_W-1:0]        out_val;
   logic [DATA_W-1:0]        m_dat;
   logic                     m_vld;
   logic                     m_last;
   logic                     beat_acc;
   logic                     last_pos;
   logic                     load;
   logic                     lb_wr;

   assign S_AXIS_DataIn_tready  = !ARESET && (!m_vld || M_AXIS_DataOut_tready);
   assign M_AXIS_DataOut_tdata  = m_dat;
   assign M_AXIS_DataOut_tvalid = m_vld;
   assign M_AXIS_DataOut_tlast  = m_last;

   assign in_dat   = S_AXIS_DataIn_tdata;
   assign beat_acc = S_AXIS_DataIn_tvalid && S_AXIS_DataIn_tready;
   assign last_pos = (col == COL_W'(MAP_W - 1)) && (row == ROW_W'(MAP_H - 1));
   assign load     = beat_acc && col[0] && row[0];
   assign lb_wr    = beat_acc && col[0] && !row[0];
   assign lb_addr  = LB_AW'(col >> 1);

   // Max first, then one sign test does the ReLU (and feeds the saturator when requant is on).
   always_comb begin
      pair_w = smax(64'(hold), 64'(in_dat));
      pool_w = smax(64'(lb_rd), pair_w);
      shf_w  = pool_w >>> EFF_SHIFT;
`ifdef AXIS_POOL_REQUANT_EN
      out_val = DATA_W'(sat_u8(shf_w));
`else
      out_val = (shf_w < 0) ? '0 : DATA_W'(shf_w);
`endif
   end

   pool_line_buf #(
      .DEPTH  (MAP_W / 2),
      .DATA_W (DATA_W),
      .ADDR_W (LB_AW)
   ) u_line_buf (
      .clk     (ACLK),
      .wr_en   (lb_wr),
      .wr_addr (lb_addr),
      .wr_dat  (pair_w[DATA_W-1:0]),
      .rd_addr (lb_addr),
      .rd_dat  (lb_rd)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         col        <= '0;
         row        <= '0;
         hold       <= '0;
         m_dat      <= '0;
         m_vld      <= 1'b0;
         m_last     <= 1'b0;
         frame_done <= 1'b0;
         err_tlast  <= 1'b0;
      end else begin
         frame_done <= m_vld && M_AXIS_DataOut_tready && m_last;
         if (m_vld && M_AXIS_DataOut_tready)
            m_vld <= 1'b0;
         if (load) begin
            m_vld  <= 1'b1;
            m_dat  <= out_val;
            m_last <= last_pos;
         end
         if (beat_acc) begin
            if (!col[0])
               hold <= in_dat;
            if (S_AXIS_DataIn_tlast != last_pos)
               err_tlast <= 1'b1;
            // An early tlast resyncs the raster to the start of the next map.
            if (last_pos || S_AXIS_DataIn_tlast) begin
               col <= '0;
               row <= '0;
            end else if (col == COL_W'(MAP_W - 1)) begin
               col <= '0;
               row <= row + ROW_W'(1);
            end else begin
               col <= col + COL_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_axis_relu_maxpool.sv
// Bench for axis_relu_maxpool: a 4x4 instance for table frames and corner sequences,
// and a 24x24 instance under a toggling output ready.
`timescale 1ns/1ps
module tb_axis_relu_maxpool;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [31:0] dat;
      logic        last;
   } exp_t;

   typedef struct packed {
      logic [15:0][31:0] px;
      logic [3:0][31:0]  expv;
   } vec_t;

   exp_t q4[$];
   exp_t q24[$];

   // 4x4 instance signals
   logic        rst4, s4_vld, s4_rdy, s4_last, m4_vld, m4_rdy, m4_last, fd4, err4;
   logic [31:0] s4_dat, m4_dat;
   // 24x24 instance signals
   logic        rst24, s24_vld, s24_rdy, s24_last, m24_vld, m24_rdy, m24_last, fd24, err24;
   logic [31:0] s24_dat, m24_dat;

   bit done4 = 1'b0;
   bit done24 = 1'b0;

   axis_relu_maxpool #(.DATA_W(32), .MAP_W(4), .MAP_H(4), .OUT_SHIFT(8)) dut4 (
      .ACLK                  (clk),
      .ARESET                (rst4),
      .S_AXIS_DataIn_tdata   (s4_dat),
      .S_AXIS_DataIn_tvalid  (s4_vld),
      .S_AXIS_DataIn_tready  (s4_rdy),
      .S_AXIS_DataIn_tlast   (s4_last),
      .M_AXIS_DataOut_tdata  (m4_dat),
      .M_AXIS_DataOut_tvalid (m4_vld),
      .M_AXIS_DataOut_tready (m4_rdy),
      .M_AXIS_DataOut_tlast  (m4_last),
      .frame_done            (fd4),
      .err_tlast             (err4)
   );

   axis_relu_maxpool #(.DATA_W(32), .MAP_W(24), .MAP_H(24), .OUT_SHIFT(8)) dut24 (
      .ACLK                  (clk),
      .ARESET                (rst24),
      .S_AXIS_DataIn_tdata   (s24_dat),
      .S_AXIS_DataIn_tvalid  (s24_vld),
      .S_AXIS_DataIn_tready  (s24_rdy),
      .S_AXIS_DataIn_tlast   (s24_last),
      .M_AXIS_DataOut_tdata  (m24_dat),
      .M_AXIS_DataOut_tvalid (m24_vld),
      .M_AXIS_DataOut_tready (m24_rdy),
      .M_AXIS_DataOut_tlast  (m24_last),
      .frame_done            (fd24),
      .err_tlast             (err24)
   );

   function automatic logic [31:0] expf(input logic signed [31:0] mx);
`ifdef AXIS_POOL_REQUANT_EN
      logic signed [31:0] s;
      s = mx >>> 8;
      if (s < 0) return 32'd0;
      else if (s > 255) return 32'd255;
      else return s;
`else
      return (mx < 0) ? 32'd0 : mx;
`endif
   endfunction

   function automatic logic signed [31:0] max4(input logic signed [31:0] a, b, c, d);
      logic signed [31:0] m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
      end
   endtask

   task automatic send4(input logic [31:0] d, input logic l);
      int n = 0;
      s4_dat = d; s4_last = l; s4_vld = 1'b1;
      while (1) begin
         @(negedge clk);
         if (s4_rdy) break;
         n++;
         if (n > 50) begin
            checks++; errors++;
            $display("FAIL send4 timeout actual=stalled required=accepted");
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic idle4(input int n);
      s4_vld = 1'b0; s4_last = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send24(input logic [31:0] d, input logic l);
      int n = 0;
      s24_dat = d; s24_last = l; s24_vld = 1'b1;
      while (1) begin
         @(negedge clk);
         if (s24_rdy) break;
         n++;
         if (n > 50) begin
            checks++; errors++;
            $display("FAIL send24 timeout actual=stalled required=accepted");
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   // Output monitors: compare accepted beats against the scoreboard queues.
   int fd4_cnt = 0;
   int fd24_cnt = 0;
   int beats24 = 0;
   logic        stall24 = 1'b0;
   logic [31:0] hold24_dat;
   logic        hold24_last;

   always @(negedge clk) begin
      exp_t e;
      if (fd4) fd4_cnt++;
      if (m4_vld && m4_rdy) begin
         if (q4.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut4 unexpected beat actual=0x%0h required=none", m4_dat);
         end else begin
            e = q4.pop_front();
            chk("dut4 data", m4_dat, e.dat);
            chk("dut4 tlast", 32'(m4_last), 32'(e.last));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (fd24) fd24_cnt++;
      if (stall24) begin
         chk("dut24 stall valid", 32'(m24_vld), 32'd1);
         chk("dut24 stall data", m24_dat, hold24_dat);
         chk("dut24 stall tlast", 32'(m24_last), 32'(hold24_last));
      end
      stall24 = m24_vld && !m24_rdy;
      hold24_dat = m24_dat;
      hold24_last = m24_last;
      if (m24_vld && m24_rdy) begin
         beats24++;
         if (q24.size() == 0) begin
            checks++; errors++;
            $display("FAIL dut24 unexpected beat actual=0x%0h required=none", m24_dat);
         end else begin
            e = q24.pop_front();
            chk("dut24 data", m24_dat, e.dat);
            chk("dut24 tlast", 32'(m24_last), 32'(e.last));
         end
      end
   end

   // 4x4 table frames and corner sequences
   initial begin
      vec_t vecs[3];
      rst4 = 1'b1; s4_vld = 1'b0; s4_last = 1'b0; s4_dat = '0; m4_rdy = 1'b1;

      for (int i = 0; i < 16; i++) vecs[0].px[i] = 32'(i + 1);
`ifdef AXIS_POOL_REQUANT_EN
      vecs[0].expv = {32'd0, 32'd0, 32'd0, 32'd0};
`else
      vecs[0].expv = {32'd16, 32'd14, 32'd8, 32'd6};
`endif
      for (int i = 0; i < 16; i++) vecs[1].px[i] = -32'sd5;
      vecs[1].px[15] = -32'sd1;
      vecs[1].expv = {32'd0, 32'd0, 32'd0, 32'd0};
      vecs[2].px = '0;
      vecs[2].px[0]  = 32'h0001_2345; vecs[2].px[1]  = 32'h100;
      vecs[2].px[4]  = -32'sd3;       vecs[2].px[5]  = 32'h2000;
      vecs[2].px[2]  = 32'h100;       vecs[2].px[3]  = 32'h8000_0000;
      vecs[2].px[6]  = 32'h4000;      vecs[2].px[7]  = 32'h3FFF;
      vecs[2].px[8]  = -32'sd7;       vecs[2].px[9]  = 32'h300;
      vecs[2].px[12] = -32'sd1;       vecs[2].px[13] = 32'h2FF;
      vecs[2].px[10] = -32'sd1; vecs[2].px[11] = -32'sd1;
      vecs[2].px[14] = -32'sd1; vecs[2].px[15] = -32'sd1;
`ifdef AXIS_POOL_REQUANT_EN
      vecs[2].expv = {32'h0, 32'h3, 32'h40, 32'hFF};
`else
      vecs[2].expv = {32'h0, 32'h300, 32'h4000, 32'h0001_2345};
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst tvalid", 32'(m4_vld), 32'd0);
      chk("rst tdata", m4_dat, 32'd0);
      chk("rst tlast", 32'(m4_last), 32'd0);
      chk("rst frame_done", 32'(fd4), 32'd0);
      chk("rst err_tlast", 32'(err4), 32'd0);
      chk("rst s_tready", 32'(s4_rdy), 32'd0);
      @(posedge clk); #1;
      rst4 = 1'b0;

      for (int v = 0; v < 3; v++) begin
         for (int k = 0; k < 4; k++) q4.push_back('{dat: vecs[v].expv[k], last: (k == 3)});
         for (int i = 0; i < 16; i++) send4(vecs[v].px[i], i == 15);
         idle4(4);
      end
      chk("table queue drained", 32'(q4.size()), 32'd0);
      chk("table err_tlast", 32'(err4), 32'd0);
      chk("table frame_done count", 32'(fd4_cnt), 32'd3);

      // Early tlast on beat 9: rows 0-1 still pool, then the raster resyncs.
      q4.push_back('{dat: expf(32'sd6), last: 1'b0});
      q4.push_back('{dat: expf(32'sd8), last: 1'b0});
      for (int i = 0; i < 10; i++) send4(32'(i + 1), i == 9);
      idle4(4);
      chk("early tlast err_tlast", 32'(err4), 32'd1);
      chk("early tlast queue drained", 32'(q4.size()), 32'd0);
      for (int k = 0; k < 4; k++) q4.push_back('{dat: vecs[0].expv[k], last: (k == 3)});
      for (int i = 0; i < 16; i++) send4(vecs[0].px[i], i == 15);
      idle4(4);
      chk("resync queue drained", 32'(q4.size()), 32'd0);
      chk("resync err sticky", 32'(err4), 32'd1);
      chk("resync frame_done count", 32'(fd4_cnt), 32'd4);

      // Reset with a pooled beat stuck in the output register.
      m4_rdy = 1'b0;
      for (int i = 0; i < 6; i++) send4(32'(i + 1), 1'b0);
      idle4(2);
      chk("pending tvalid", 32'(m4_vld), 32'd1);
      chk("pending tdata", m4_dat, expf(32'sd6));
      chk("pending s_tready", 32'(s4_rdy), 32'd0);
      rst4 = 1'b1;
      @(posedge clk); #1;
      rst4 = 1'b0;
      @(negedge clk);
      chk("abort tvalid dropped", 32'(m4_vld), 32'd0);
      chk("abort err cleared", 32'(err4), 32'd0);
      @(posedge clk); #1;
      m4_rdy = 1'b1;
      idle4(2);
      for (int k = 0; k < 4; k++) q4.push_back('{dat: vecs[0].expv[k], last: (k == 3)});
      for (int i = 0; i < 16; i++) send4(vecs[0].px[i], i == 15);
      idle4(4);
      chk("post-reset queue drained", 32'(q4.size()), 32'd0);
      chk("post-reset frame_done count", 32'(fd4_cnt), 32'd5);
      chk("post-reset err_tlast", 32'(err4), 32'd0);
      done4 = 1'b1;
   end

   // 24x24 scrambled ramp with output ready toggling every cycle
   initial begin
      m24_rdy = 1'b0;
      @(posedge clk); #1;
      forever begin
         m24_rdy = ~m24_rdy;
         @(posedge clk); #1;
      end
   end

   initial begin
      logic signed [31:0] px24 [576];
      int wait_n;
      rst24 = 1'b1; s24_vld = 1'b0; s24_last = 1'b0; s24_dat = '0;
      for (int i = 0; i < 576; i++) px24[i] = ((i * 37) % 101) - 50;
      for (int wr = 0; wr < 12; wr++)
         for (int wc = 0; wc < 12; wc++)
            q24.push_back('{dat: expf(max4(px24[(2*wr)*24 + 2*wc], px24[(2*wr)*24 + 2*wc + 1],
                                           px24[(2*wr+1)*24 + 2*wc], px24[(2*wr+1)*24 + 2*wc + 1])),
                            last: (wr == 11) && (wc == 11)});
      repeat (3) @(posedge clk); #1;
      rst24 = 1'b0;
      for (int i = 0; i < 576; i++) send24(px24[i], i == 575);
      s24_vld = 1'b0; s24_last = 1'b0;
      wait_n = 0;
      while (q24.size() != 0 && wait_n < 2000) begin
         @(posedge clk);
         wait_n++;
      end
      repeat (4) @(posedge clk);
      chk("dut24 queue drained", 32'(q24.size()), 32'd0);
      chk("dut24 beat count", 32'(beats24), 32'd144);
      chk("dut24 frame_done count", 32'(fd24_cnt), 32'd1);
      chk("dut24 err_tlast", 32'(err24), 32'd0);
      done24 = 1'b1;
   end

   initial begin
      int n = 0;
      while (!(done4 && done24) && n < 60000) begin
         @(posedge clk);
         n++;
      end
      if (!(done4 && done24)) begin
         checks++; errors++;
         $display("FAIL run timeout actual=unfinished required=finished");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
